fetch_unit_pipelined: RTL and testbench

- Parametrised next-generation instruction-fetch stage for the pipelined processor.
- Issues PC-addressed requests to an instruction memory over a valid/ready request and valid-only response interface, with bounded outstanding requests.
- Buffers returned instructions in a small in-order FIFO and drives the IF/ID register (InstrD, PCD, PCPlus4D).
- Supports decode stall, decode flush and execute-stage branch redirect, with squashing of in-flight responses.

---
 rtl/fetch_unit_pipelined.sv | 150 +++++++++++++++
 tb/tb_fetch_unit_pipelined.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_pipelined.sv
// Instruction fetch stage: credit-limited imem requests, in-order
// instruction buffer and IF/ID register with stall/flush/redirect.
module fetch_unit_pipelined #(
  parameter int PC_W = 9,
  parameter int INSTR_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  input  logic               StallD,
  input  logic               FlushD,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
);

  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int QW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((OW > CW) ? OW : CW) + 1;

  logic              started;
  logic [PC_W-1:0]   pcF;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     drop;

  logic [PC_W-1:0]   pcq [MAX_OUTSTANDING];
  logic [QW-1:0]     qHead;
  logic [QW-1:0]     qTail;

  logic [INSTR_W-1:0] fData [FIFO_DEPTH];
  logic [PC_W-1:0]    fPc [FIFO_DEPTH];
  logic [FW-1:0]      fHead;
  logic [FW-1:0]      fTail;
  logic [CW-1:0]      fCnt;

  logic [SW-1:0] inUse;
  logic          issue;
  logic          respIn;
  logic          respDrop;
  logic          respKeep;
  logic          ifPop;

  function automatic logic [QW-1:0] qInc(
    input logic [QW-1:0] p
  );
    return (p == QW'(MAX_OUTSTANDING - 1)) ?
      '0 : p + QW'(1);
  endfunction

  // Credit covers both buffered and in-flight words
  assign inUse = SW'(outstanding) + SW'(fCnt);

  assign imem_req_valid = started && !PCSrcE &&
    (outstanding < OW'(MAX_OUTSTANDING)) &&
    (inUse < SW'(FIFO_DEPTH));
  assign imem_addr = pcF;

  assign issue    = imem_req_valid && imem_req_ready;
  assign respIn   = imem_resp_valid && started &&
    (outstanding != '0);
  assign respDrop = respIn && (drop != '0);
  assign respKeep = respIn && (drop == '0) && !PCSrcE;
  assign ifPop    = !PCSrcE && !FlushD && !StallD &&
    (fCnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started     <= 1'b0;
      pcF         <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      qHead       <= '0;
      qTail       <= '0;
      fHead       <= '0;
      fTail       <= '0;
      fCnt        <= '0;
      ValidD      <= 1'b0;
      InstrD      <= '0;
      PCD         <= '0;
      PCPlus4D    <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + OW'(issue) - OW'(respIn);
      if (PCSrcE) begin
        pcF    <= PCTargetE & ~PC_W'(3);
        drop   <= outstanding - OW'(respIn);
        qHead  <= '0;
        qTail  <= '0;
        fHead  <= '0;
        fTail  <= '0;
        fCnt   <= '0;
        ValidD <= 1'b0;
        InstrD <= '0;
      end else begin
        if (issue) begin
          pcF   <= pcF + PC_W'(4);
          qTail <= qInc(qTail);
        end
        if (respDrop) drop <= drop - OW'(1);
        if (respKeep) begin
          qHead <= qInc(qHead);
          fTail <= fTail + FW'(1);
        end
        if (ifPop) fHead <= fHead + FW'(1);
        fCnt <= fCnt + CW'(respKeep) - CW'(ifPop);
        if (FlushD) begin
          ValidD <= 1'b0;
          InstrD <= '0;
        end else if (!StallD) begin
          if (fCnt != '0) begin
            ValidD   <= 1'b1;
            InstrD   <= fData[fHead];
            PCD      <= fPc[fHead];
            PCPlus4D <= fPc[fHead] + PC_W'(4);
          end else begin
            ValidD <= 1'b0;
            InstrD <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pcq[qTail] <= pcF;
    if (respKeep) begin
      fData[fTail] <= imem_resp_data;
      fPc[fTail]   <= pcq[qHead];
    end
  end

  a_noOverflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(respKeep && fCnt == CW'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_fetch_unit_pipelined.sv
// Random and directed bench for fetch_unit_pipelined against a
// queue-based model of the fetch stream and memory.
module tb_fetch_unit_pipelined;

  localparam int PW = 9;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          PCSrcE = 1'b0;
  logic [PW-1:0] PCTargetE = '0;
  logic          StallD = 1'b0;
  logic          FlushD = 1'b0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [PW-1:0] imem_addr;
  logic          imem_resp_valid = 1'b0;
  logic [31:0]   imem_resp_data = '0;
  logic [31:0]   InstrD;
  logic [PW-1:0] PCD;
  logic [PW-1:0] PCPlus4D;
  logic          ValidD;

  always #5 clk = ~clk;

  fetch_unit_pipelined #(
    .PC_W(PW),
    .INSTR_W(32),
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(9'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .StallD(StallD),
    .FlushD(FlushD),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .InstrD(InstrD),
    .PCD(PCD),
    .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  typedef struct {
    logic [PW-1:0] addr;
    int            due;
  } memReq_t;

  typedef struct {
    logic [PW-1:0] pc;
    logic [31:0]   data;
  } item_t;

  memReq_t       memQ[$];
  item_t         mFifo[$];
  item_t         delivered[$];
  logic [PW-1:0] hsLog[$];

  logic [PW-1:0] mPC, mPCD, mPC4;
  logic [31:0]   mInstr;
  bit            mValid, mStarted, mReqV;
  int            mOut, mDrop, lastDue;

  bit            dRst = 0, dSrc = 0, dStall = 0;
  bit            dFlush = 0, dReady = 1, inj = 0, pinA = 0;
  logic [PW-1:0] dTgt = '0;
  int            lat = 1;
  int            cyc = 0, rel = 0, firstValid = -1;
  int            wrapSeen = 0;
  int            checks = 0, errors = 0;

  function automatic logic [31:0] memData(
    input logic [PW-1:0] a
  );
    return {16'hC0DE, 7'h00, a};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mPC = '0;
    mPCD = '0;
    mPC4 = '0;
    mInstr = '0;
    mValid = 0;
    mStarted = 0;
    mOut = 0;
    mDrop = 0;
    mFifo.delete();
    memQ.delete();
    lastDue = -1;
  endtask

  task automatic step();
    bit resp, hs;
    logic [PW-1:0] rAddr;
    memReq_t m;
    item_t it;
    if (!rst) begin
      modelReset();
      rel = -1;
      return;
    end
    rAddr = '0;
    resp = imem_resp_valid && mStarted && (mOut > 0);
    if (imem_resp_valid && !inj && memQ.size() > 0) begin
      m = memQ.pop_front();
      rAddr = m.addr;
    end
    hs = mReqV && dReady;
    if (hs) begin
      m.addr = mPC;
      m.due = cyc + lat;
      if (m.due <= lastDue) m.due = lastDue + 1;
      lastDue = m.due;
      memQ.push_back(m);
      hsLog.push_back(mPC);
    end
    if (dSrc) begin
      mValid = 0;
      mInstr = '0;
      mFifo.delete();
      mOut = mOut - int'(resp);
      mDrop = mOut;
      mPC = dTgt & 9'h1FC;
    end else begin
      if (dFlush) begin
        mValid = 0;
        mInstr = '0;
      end else if (!dStall) begin
        if (mFifo.size() > 0) begin
          it = mFifo.pop_front();
          mValid = 1;
          mInstr = it.data;
          mPCD = it.pc;
          mPC4 = it.pc + 9'd4;
          delivered.push_back(it);
        end else begin
          mValid = 0;
          mInstr = '0;
        end
      end
      if (resp) begin
        if (mDrop > 0) mDrop--;
        else mFifo.push_back('{rAddr, memData(rAddr)});
      end
      if (hs) begin
        mPC = mPC + 9'd4;
        mOut++;
      end
      if (resp) mOut--;
    end
    mStarted = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    rst = dRst;
    PCSrcE = dSrc;
    PCTargetE = dTgt;
    StallD = dStall;
    FlushD = dFlush;
    imem_req_ready = dReady;
    if (inj) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = 32'hBAD0BAD0;
    end else if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = memData(memQ[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
    end
    #1;
    mReqV = mStarted && !dSrc && (mOut < MAXO) &&
            (mOut + mFifo.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(mReqV));
    chk("imem_addr", 32'(imem_addr), 32'(mPC));
    chk("ValidD", 32'(ValidD), 32'(mValid));
    chk("InstrD", InstrD, mInstr);
    chk("PCD", 32'(PCD), 32'(mPCD));
    chk("PCPlus4D", 32'(PCPlus4D), 32'(mPC4));
    if (ValidD === 1'b1 && firstValid < 0) firstValid = rel;
    if (pinA && rel == 8)
      chk("credit_stop8", 32'(imem_req_valid), 32'd0);
    if (pinA && rel == 9) begin
      chk("credit_stop9", 32'(imem_req_valid), 32'd0);
      chk("stall_hold", 32'(PCD), 32'h008);
    end
    if (pinA && rel == 10)
      chk("stall_release", 32'(PCD), 32'h00C);
    if (ValidD === 1'b1 && PCD === 9'h1FC) begin
      wrapSeen++;
      chk("wrap_pc4", 32'(PCPlus4D), 32'h000);
    end
    @(posedge clk);
    step();
    cyc++;
    rel++;
  endtask

  task automatic doReset();
    dRst = 0;
    cycle();
    cycle();
    dRst = 1;
    firstValid = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    modelReset();

    // Sequential fetch with a 3-cycle decode stall at PCD=0x08
    doReset();
    lat = 1;
    dReady = 1;
    pinA = 1;
    delivered.delete();
    for (int i = 0; i < 16; i++) begin
      dStall = (rel >= 6 && rel <= 8);
      cycle();
    end
    pinA = 0;
    dStall = 0;
    chk("first_valid_cycle", 32'(firstValid), 32'd4);
    chk("seq_count", 32'(delivered.size() >= 5), 32'd1);
    if (delivered.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("seq_pc%0d", i),
            32'(delivered[i].pc), 32'(4 * i));
      chk("seq_data2", delivered[2].data, 32'hC0DE0008);
    end

    // Request backpressure
    dReady = 0;
    for (int i = 0; i < 4; i++) cycle();
    dReady = 1;
    for (int i = 0; i < 8; i++) cycle();

    // Redirect with two requests in flight
    lat = 3;
    for (int i = 0; i < 30 && mOut != 2; i++) cycle();
    chk("redir_setup", 32'(mOut), 32'd2);
    idx = hsLog.size();
    dSrc = 1;
    dTgt = 9'h041;
    cycle();
    dSrc = 0;
    delivered.delete();
    for (int i = 0; i < 20; i++) cycle();
    chk("redir_n", 32'(hsLog.size() > idx &&
                       delivered.size() > 0), 32'd1);
    if (hsLog.size() > idx && delivered.size() > 0) begin
      chk("redir_addr", 32'(hsLog[idx]), 32'h040);
      chk("redir_pcd", 32'(delivered[0].pc), 32'h040);
    end

    // Wrap-around at the top of the address space
    lat = 1;
    dSrc = 1;
    dTgt = 9'h1FC;
    cycle();
    dSrc = 0;
    delivered.delete();
    for (int i = 0; i < 10; i++) cycle();
    chk("wrap_seen", 32'(wrapSeen > 0), 32'd1);
    chk("wrap_n", 32'(delivered.size() >= 2), 32'd1);
    if (delivered.size() >= 2) begin
      chk("wrap_pc0", 32'(delivered[0].pc), 32'h1FC);
      chk("wrap_pc1", 32'(delivered[1].pc), 32'h000);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      dStall = ($urandom_range(0, 3) == 0);
      dFlush = ($urandom_range(0, 7) == 0);
      dSrc = ($urandom_range(0, 19) == 0);
      dTgt = 9'($urandom);
      dReady = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      cycle();
    end
    dSrc = 0;
    dFlush = 0;
    dReady = 1;

    // Asynchronous reset with work in flight and buffered
    lat = 3;
    dStall = 1;
    for (int i = 0; i < 40 &&
         !(mOut >= 1 && mFifo.size() >= 2); i++)
      cycle();
    chk("midrst_setup",
        32'(mOut >= 1 && mFifo.size() >= 2), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ValidD", 32'(ValidD), 32'd0);
    chk("rst_InstrD", InstrD, 32'd0);
    chk("rst_PCD", 32'(PCD), 32'd0);
    chk("rst_PCPlus4D", 32'(PCPlus4D), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    modelReset();
    dRst = 0;
    dStall = 0;
    lat = 1;
    cycle();
    dRst = 1;
    inj = 1;
    idx = hsLog.size();
    delivered.delete();
    cycle();
    inj = 0;
    for (int i = 0; i < 12; i++) cycle();
    chk("restart_n", 32'(hsLog.size() > idx &&
                         delivered.size() > 0), 32'd1);
    if (hsLog.size() > idx && delivered.size() > 0) begin
      chk("restart_addr", 32'(hsLog[idx]), 32'h000);
      chk("restart_pcd", 32'(delivered[0].pc), 32'h000);
      chk("restart_data", delivered[0].data, 32'hC0DE0000);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
